// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - VRAM port-A arbiter between a queued CPU write path and a block-fill engine
module vram_port_arbiter #(
    parameter int AW    = 10,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data,
    output logic          cpu_stall,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW:0]   fill_len,
    input  logic [DW-1:0] fill_value,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          v_cea,
    output logic [AW-1:0] v_ada,
    output logic [DW-1:0] v_din
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CNT_ONE    = (PW+1)'(1);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // CPU write FIFO: entries are {addr, data}
    logic [AW+DW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      fifo_count;
    logic [PW:0]      fifo_count_next;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [AW+DW-1:0] fifo_head;

    logic [0:0]    state;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic [DW-1:0] value_q;
    logic [AW:0]   fill_cnt;
    logic [AW-1:0] fill_addr;
    logic          fill_last;
    logic          last_grant_fill;

    logic fifo_pending;
    logic fill_pending;
    logic grant_cpu;
    logic grant_fill;

    assign cpu_stall    = fifo_full;
    assign fill_busy    = (state == ST_FILL);
    assign push         = cpu_we && !fifo_full;
    assign pop          = grant_cpu;
    assign fifo_head    = fifo_mem[rd_ptr];
    assign fifo_pending = (fifo_count != '0);
    assign fill_pending = (state == ST_FILL);
    assign fill_addr    = base_q + fill_cnt[AW-1:0];
    assign fill_last    = ((fill_cnt + (AW+1)'(1)) == len_q);

    // Round-robin only matters under contention; otherwise the sole requester wins.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_fill = 1'b0;
        if (fifo_pending && fill_pending) begin
            grant_cpu  = last_grant_fill;
            grant_fill = !last_grant_fill;
        end else begin
            grant_cpu  = fifo_pending;
            grant_fill = fill_pending;
        end
    end

    always_comb begin
        fifo_count_next = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + CNT_ONE;
            2'b01:   fifo_count_next = fifo_count - CNT_ONE;
            default: fifo_count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cpu_addr, cpu_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count_next;
            fifo_full  <= (fifo_count_next == FULL_COUNT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            base_q          <= '0;
            len_q           <= '0;
            value_q         <= '0;
            fill_cnt        <= '0;
            fill_done       <= 1'b0;
            last_grant_fill <= 1'b1;
            v_cea           <= 1'b0;
            v_ada           <= '0;
            v_din           <= '0;
        end else begin
            fill_done <= 1'b0;
            v_cea     <= grant_cpu | grant_fill;
            if (grant_cpu) begin
                v_ada           <= fifo_head[AW+DW-1:DW];
                v_din           <= fifo_head[DW-1:0];
                last_grant_fill <= 1'b0;
            end else if (grant_fill) begin
                v_ada           <= fill_addr;
                v_din           <= value_q;
                last_grant_fill <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        if (fill_len == '0) begin
                            fill_done <= 1'b1;
                        end else begin
                            base_q   <= fill_base;
                            len_q    <= fill_len;
                            value_q  <= fill_value;
                            fill_cnt <= '0;
                            state    <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    // fill_done rises together with the final write on the port.
                    if (grant_fill) begin
                        fill_cnt <= fill_cnt + (AW+1)'(1);
                        if (fill_last) begin
                            state     <= ST_IDLE;
                            fill_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
